// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Word-organised data RAM (2^ADDR_WIDTH x 32) that serves load/store
//   requests from the ID stage. Each access takes a fixed number of wait
//   states and then reports completion with a single-cycle ram_ready pulse.
//   Misaligned word accesses are rejected with addr_error.
//
// Parameters
//   ADDR_WIDTH  : word-address width, memory depth is 2^ADDR_WIDTH words
//   WAIT_CYCLES : wait states before completion (0..15)
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   ram_en         : request valid
//   ram_write_en   : 1 = store, 0 = load
//   ram_write_sel  : byte-lane enables for stores
//   ram_addr       : byte address
//   ram_write_data : store data
//   ram_read_data  : registered load result
//   ram_ready      : one-cycle completion pulse
//   stall_req      : pipeline stall while an access is pending
//   addr_error     : misaligned-access flag, valid with ram_ready
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic        ram_write_en,
    input  logic [3:0]  ram_write_sel,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_ready,
    output logic        stall_req,
    output logic        addr_error
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Latched request (data path, no reset needed)
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH];

    // The access fires on the edge entering RESP. With zero wait states that
    // edge is the accepting edge itself, so the live inputs must be used
    // instead of the (not yet loaded) request registers.
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_mis;
    logic                  do_access;
    logic                  unused_addr_bits;

    always_comb begin
        acc_we    = we_q;
        acc_sel   = sel_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_we    = ram_write_en;
            acc_sel   = ram_write_sel;
            acc_addr  = ram_addr;
            acc_wdata = ram_write_data;
        end
    end

    // Upper address bits are dropped so accesses wrap modulo depth.
    assign acc_idx          = acc_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^acc_addr[31:ADDR_WIDTH+2];

    // Partial-lane stores may sit at an unaligned address; only full-word
    // accesses (loads, or stores of all four lanes) demand alignment.
    assign acc_mis = (acc_addr[1:0] != 2'b00) && (!acc_we || (acc_sel == 4'b1111));

    // Next-state, counter and stall logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_en) begin
                    stall_req = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Any ram_en here belongs to the request being completed.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall_req = 1'b0;
            do_access = 1'b0;
        end
    end

    // Read result and error flag update only when an access fires.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (do_access) begin
            err_d = acc_mis;
            if (acc_mis) begin
                rdata_d = 32'd0;
            end else if (!acc_we) begin
                rdata_d = mem_q[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && ram_en) begin
            we_q    <= ram_write_en;
            sel_q   <= ram_write_sel;
            addr_q  <= ram_addr;
            wdata_q <= ram_write_data;
        end
    end

    // Memory is not reset; a reset only blocks a write that would fire on
    // the same edge.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ram_read_data = rdata_q;
    assign ram_ready     = (state_q == RESP);
    assign addr_error    = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder. Three instances (WAIT_CYCLES = 1, 3
// and 0) share the request inputs; only the instance selected by 'cur' is
// out of reset at any time, and its outputs are routed to the checkers.
module tb_data_ram_responder;

    logic        clk;
    logic        rst1, rst3, rst0;
    logic        ram_en;
    logic        ram_write_en;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;

    logic [31:0] rd1, rd3, rd0;
    logic        rdy1, rdy3, rdy0;
    logic        stl1, stl3, stl0;
    logic        err1, err3, err0;

    logic [31:0] rd_s;
    logic        rdy_s, stl_s, err_s;
    int          cur;

    int vec_cnt;
    int err_cnt;

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst1), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_write_sel(ram_write_sel), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_data(rd1), .ram_ready(rdy1), .stall_req(stl1), .addr_error(err1)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst3), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_write_sel(ram_write_sel), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_data(rd3), .ram_ready(rdy3), .stall_req(stl3), .addr_error(err3)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst0), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_write_sel(ram_write_sel), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_data(rd0), .ram_ready(rdy0), .stall_req(stl0), .addr_error(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rd_s  = rd1;
        rdy_s = rdy1;
        stl_s = stl1;
        err_s = err1;
        if (cur == 3) begin
            rd_s = rd3; rdy_s = rdy3; stl_s = stl3; err_s = err3;
        end else if (cur == 0) begin
            rd_s = rd0; rdy_s = rdy0; stl_s = stl0; err_s = err0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request on the selected instance. Starts and ends on a
    // falling edge.
    task automatic do_op(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd, input int w,
                         input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
        ram_en         = 1'b1;
        ram_write_en   = we;
        ram_write_sel  = sel;
        ram_addr       = addr;
        ram_write_data = wd;
        #1;
        chk({tag, "_stall_req"}, 32'(stl_s), 32'd1);
        chk({tag, "_ready_idle"}, 32'(rdy_s), 32'd0);
        @(posedge clk);
        #1 ram_en = 1'b0;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            chk({tag, "_stall_wait"}, 32'(stl_s), 32'd1);
            chk({tag, "_ready_wait"}, 32'(rdy_s), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rdy_s), 32'd1);
        chk({tag, "_stall_resp"}, 32'(stl_s), 32'd0);
        chk({tag, "_addr_error"}, 32'(err_s), 32'(exp_err));
        if (chk_rd) chk({tag, "_rdata"}, rd_s, exp_rd);
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(rdy_s), 32'd0);
        chk({tag, "_err_after"}, 32'(err_s), 32'd0);
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        cur            = 1;
        rst1           = 1'b1;
        rst3           = 1'b1;
        rst0           = 1'b1;
        ram_en         = 1'b1;
        ram_write_en   = 1'b0;
        ram_write_sel  = 4'h0;
        ram_addr       = 32'h0;
        ram_write_data = 32'h0;

        // Reset state; ram_en high must not raise stall_req during reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rd_s, 32'd0);
        chk("rst_ready", 32'(rdy_s), 32'd0);
        chk("rst_err", 32'(err_s), 32'd0);
        chk("rst_stall", 32'(stl_s), 32'd0);
        ram_en = 1'b0;
        rst1   = 1'b0;
        @(negedge clk);

        // WAIT_CYCLES = 1: basic store / load
        do_op("st40", 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1, 1'b1, 32'd0, 1'b0);
        do_op("ld40", 1'b0, 4'hF, 32'h40, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte lanes; store completions keep the previous read data
        do_op("st80", 1'b1, 4'hF, 32'h80, 32'h11223344, 1, 1'b1, 32'hDEADBEEF, 1'b0);
        do_op("st80_lanes", 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, 1, 1'b1, 32'hDEADBEEF, 1'b0);
        do_op("ld80", 1'b0, 4'hF, 32'h80, 32'h0, 1, 1'b1, 32'h11BB33DD, 1'b0);

        // Misaligned load, then aligned load
        do_op("ld42_mis", 1'b0, 4'hF, 32'h42, 32'h0, 1, 1'b1, 32'd0, 1'b1);
        do_op("ld40_after", 1'b0, 4'hF, 32'h40, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);

        // Misaligned full-word store must not write; empty lane mask must not write
        do_op("st42_mis", 1'b1, 4'hF, 32'h42, 32'h55555555, 1, 1'b0, 32'd0, 1'b1);
        do_op("st40_nosel", 1'b1, 4'h0, 32'h40, 32'h66666666, 1, 1'b0, 32'd0, 1'b0);
        do_op("ld40_kept", 1'b0, 4'hF, 32'h40, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);

        // Partial store at unaligned address is legal; load ignores sel
        do_op("st82_half", 1'b1, 4'b0011, 32'h82, 32'h00005566, 1, 1'b0, 32'd0, 1'b0);
        do_op("ld80_sel0", 1'b0, 4'h0, 32'h80, 32'h0, 1, 1'b1, 32'h11BB5566, 1'b0);

        // Wrap-around: 0x1000 maps onto word 0
        do_op("st1000", 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 1, 1'b0, 32'd0, 1'b0);
        do_op("ld0_wrap", 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b1, 32'hCAFEF00D, 1'b0);

        // Reset leaves memory intact but clears read data
        rst1 = 1'b1;
        @(negedge clk);
        chk("rst2_rdata", rd_s, 32'd0);
        rst1 = 1'b0;
        @(negedge clk);
        do_op("ld40_postrst", 1'b0, 4'hF, 32'h40, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);
        rst1 = 1'b1;

        // WAIT_CYCLES = 3: reset in the middle of a store
        cur  = 3;
        rst3 = 1'b0;
        @(negedge clk);
        do_op("w3_st10", 1'b1, 4'hF, 32'h10, 32'h0BADF00D, 3, 1'b0, 32'd0, 1'b0);
        ram_en         = 1'b1;
        ram_write_en   = 1'b1;
        ram_write_sel  = 4'hF;
        ram_addr       = 32'h10;
        ram_write_data = 32'h12345678;
        @(posedge clk);
        #1 ram_en = 1'b0;
        @(negedge clk);
        chk("w3_abort_stall_wait", 32'(stl_s), 32'd1);
        rst3 = 1'b1;
        #1;
        chk("w3_abort_stall_rst", 32'(stl_s), 32'd0);
        @(negedge clk);
        chk("w3_abort_ready_rst", 32'(rdy_s), 32'd0);
        rst3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w3_abort_no_ready", 32'(rdy_s), 32'd0);
        end
        do_op("w3_ld10", 1'b0, 4'hF, 32'h10, 32'h0, 3, 1'b1, 32'h0BADF00D, 1'b0);
        rst3 = 1'b1;

        // WAIT_CYCLES = 0: back-to-back loads with ram_en held
        cur  = 0;
        rst0 = 1'b0;
        @(negedge clk);
        do_op("w0_st20", 1'b1, 4'hF, 32'h20, 32'h01020304, 0, 1'b0, 32'd0, 1'b0);
        ram_en        = 1'b1;
        ram_write_en  = 1'b0;
        ram_write_sel = 4'hF;
        ram_addr      = 32'h20;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("w0_b2b_ready", 32'(rdy_s), 32'(i % 2));
            chk("w0_b2b_stall", 32'(stl_s), 32'((i + 1) % 2));
            if (i % 2 == 1) chk("w0_b2b_rdata", rd_s, 32'h01020304);
            @(negedge clk);
        end
        ram_en = 1'b0;
        @(negedge clk);
        chk("w0_b2b_idle", 32'(rdy_s), 32'd0);
        rst0 = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
